// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues word reads over req/ack,
// and feeds {pc, inst, valid} into the IF/ID register.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    KILL
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;

  logic [31:0] tgt;
  logic [31:0] pc_inc;

  assign tgt    = branch_target_addr & ~32'h3;
  assign pc_inc = pc_q + 32'(PC_STEP);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: a branch leaves a pending stale read behind as KILL.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (branch_flag)          state_d = mem_ack ? REQ : KILL;
        else if (mem_ack && stall) state_d = HOLD;
      end
      HOLD: if (branch_flag || !stall) state_d = REQ;
      KILL: if (mem_ack) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // Memory request: KILL keeps the stale address until it is acked.
  always_comb begin
    mem_req  = (state_q == REQ) || (state_q == KILL);
    mem_addr = (state_q == KILL) ? kill_addr_q : pc_q;
  end

  // Datapath next values: branch wins over stall and over ack data.
  always_comb begin
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    if_valid_d  = if_valid_q;
    if (branch_flag) begin
      pc_d       = tgt;
      if_valid_d = 1'b0;
      if (state_q == REQ && !mem_ack) kill_addr_d = pc_q;
    end else begin
      unique case (state_q)
        REQ: begin
          if (mem_ack) begin
            pc_d = pc_inc;
            if (stall) begin
              skid_pc_d   = pc_q;
              skid_inst_d = mem_rdata;
            end else begin
              if_pc_d    = pc_q;
              if_inst_d  = mem_rdata;
              if_valid_d = 1'b1;
            end
          end else if (!stall) begin
            if_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_pc_d    = skid_pc_q;
            if_inst_d  = skid_inst_q;
            if_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC & ~32'h3;
      kill_addr_q <= '0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
      if_valid_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      if_valid_q  <= if_valid_d;
    end
  end

  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;
  assign if_valid = if_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: scoreboard of presented instructions plus
// per-scenario checks of the memory request side.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target_addr = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        ack_en = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  assign mem_ack   = mem_req & ack_en;
  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

  if_fetch dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .branch_flag(branch_flag),
    .branch_target_addr(branch_target_addr),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .if_pc(if_pc),
    .if_inst(if_inst),
    .if_valid(if_valid)
  );

  // A new instruction is presented on an edge with no reset and no stall.
  always @(posedge clk) begin
    logic s, r;
    logic [31:0] e;
    s = stall;
    r = rst;
    #2;
    if (!r && !s && if_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got pc=%h, expected none", if_pc);
      end else begin
        e = exp_q.pop_front();
        if (if_pc !== e || if_inst !== (e ^ 32'hA5A5_0000)) begin
          errors++;
          $display("FAIL sb_present: got pc=%h inst=%h, expected pc=%h inst=%h",
                   if_pc, if_inst, e, e ^ 32'hA5A5_0000);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req(input string nm, input logic rq, input logic [31:0] ad);
    checks++;
    if (mem_req !== rq || (rq && mem_addr !== ad)) begin
      errors++;
      $display("FAIL %s: got req=%b addr=%h, expected req=%b addr=%h",
               nm, mem_req, mem_addr, rq, ad);
    end
  endtask

  task automatic chk_vld(input string nm, input logic v);
    checks++;
    if (if_valid !== v) begin
      errors++;
      $display("FAIL %s: got if_valid=%b, expected %b", nm, if_valid, v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
      errors++;
      $display("FAIL reset: got req=%b vld=%b pc=%h inst=%h, expected 0 0 0 0",
               mem_req, if_valid, if_pc, if_inst);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    tick();
    chk_req("seq_a0", 1'b1, 32'h0);
    tick();
    chk_req("seq_a4", 1'b1, 32'h4);
    chk_vld("seq_v0", 1'b1);
    tick();
    chk_req("seq_a8", 1'b1, 32'h8);
    chk_vld("seq_v4", 1'b1);
    ack_en = 1'b0;
  endtask

  task automatic test_wait_state();
    tick();
    chk_req("wait_a8_1", 1'b1, 32'h8);
    chk_vld("wait_bub1", 1'b0);
    tick();
    chk_req("wait_a8_2", 1'b1, 32'h8);
    chk_vld("wait_bub2", 1'b0);
    ack_en = 1'b1;
    exp_q.push_back(32'h8);
    tick();
    chk_req("wait_a12", 1'b1, 32'hC);
  endtask

  task automatic test_stall_skid();
    stall = 1'b1;
    exp_q.push_back(32'hC);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_req("hold_noreq", 1'b0, 32'h0);
      checks++;
      if (if_pc !== 32'h8 || if_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_frozen: got pc=%h vld=%b, expected pc=00000008 vld=1",
                 if_pc, if_valid);
      end
    end
    stall = 1'b0;
    exp_q.push_back(32'h10);
    tick();
    chk_req("skid_a16", 1'b1, 32'h10);
  endtask

  task automatic test_kill();
    tick();
    chk_req("kill_a20", 1'b1, 32'h14);
    ack_en = 1'b0;
    branch_flag = 1'b1;
    branch_target_addr = 32'h0000_0103;
    tick();
    branch_flag = 1'b0;
    chk_req("kill_stale1", 1'b1, 32'h14);
    chk_vld("kill_v1", 1'b0);
    tick();
    chk_req("kill_stale2", 1'b1, 32'h14);
    chk_vld("kill_v2", 1'b0);
    ack_en = 1'b1;
    tick();
    chk_req("kill_tgt", 1'b1, 32'h100);
    chk_vld("kill_discard", 1'b0);
    exp_q.push_back(32'h100);
    tick();
    chk_req("kill_next", 1'b1, 32'h104);
  endtask

  task automatic test_branch_stall_ack();
    branch_flag = 1'b1;
    stall = 1'b1;
    branch_target_addr = 32'h0000_0200;
    tick();
    branch_flag = 1'b0;
    stall = 1'b0;
    chk_vld("bs_flush", 1'b0);
    chk_req("bs_tgt", 1'b1, 32'h200);
    exp_q.push_back(32'h200);
    tick();
    chk_req("bs_next", 1'b1, 32'h204);
  endtask

  task automatic test_wrap_and_reset();
    branch_flag = 1'b1;
    branch_target_addr = 32'hFFFF_FFFC;
    tick();
    branch_flag = 1'b0;
    chk_req("wrap_top", 1'b1, 32'hFFFF_FFFC);
    chk_vld("wrap_flush", 1'b0);
    exp_q.push_back(32'hFFFF_FFFC);
    tick();
    chk_req("wrap_zero", 1'b1, 32'h0);
    ack_en = 1'b0;
    tick();
    chk_vld("wrap_bub", 1'b0);
    rst = 1'b1;
    ack_en = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
      errors++;
      $display("FAIL midreset: got req=%b vld=%b pc=%h inst=%h, expected 0 0 0 0",
               mem_req, if_valid, if_pc, if_inst);
    end
    rst = 1'b0;
    tick();
    chk_req("rst_first", 1'b1, 32'h0);
    exp_q.push_back(32'h0);
    tick();
    chk_vld("rst_pres", 1'b1);
    tick();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_state();
    test_stall_skid();
    test_kill();
    test_branch_stall_ack();
    test_wrap_and_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage; the producer side of the IF/ID pipeline register.
- Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Delivers {if_pc, if_inst, if_valid} to the IF/ID register each cycle.
- Handles pipeline stall and branch redirect, and discards in-flight fetches made stale by a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high (`RstEnable).
- stall  in  1  hold request from pipeline control; IF outputs must not change while high.
- branch_flag  in  1  redirect request, valid for one cycle.
- branch_target_addr  in  32  redirect byte address; bits [1:0] are ignored (treated as 0).
- mem_req  out  1  instruction-memory read request.
- mem_addr  out  32  read address, word-aligned.
- mem_ack  in  1  read data valid this cycle; may be asserted combinationally in the same cycle as mem_req.
- mem_rdata  in  32  read data, sampled only when mem_ack=1.
- if_pc  out  32  PC of the presented instruction (to IF/ID).
- if_inst  out  32  presented instruction (to IF/ID).
- if_valid  out  1  1 = if_pc/if_inst hold a real instruction; 0 = bubble.

Behaviour:
- Registered outputs: if_pc, if_inst, if_valid. mem_req and mem_addr are driven from state and pc_reg.
- Reset (rst=1 at posedge, any state, including mid-fetch or stalled):
  - pc_reg=RESET_PC, state=IDLE, skid buffer empty.
  - mem_req=0; if_pc=0, if_inst=0, if_valid=0.
  - Any ack arriving after reset is ignored.
- States: IDLE, REQ, HOLD, KILL.
- IDLE: mem_req=0. Go to REQ on the next cycle.
- REQ: mem_req=1, mem_addr=pc_reg. mem_req and mem_addr stay stable until mem_ack.
  - ack=1, no stall, no branch: if_pc<=pc_reg, if_inst<=mem_rdata, if_valid<=1, pc_reg<=pc_reg+PC_STEP. Stay in REQ; the new address is presented next cycle. Zero-wait memory gives 1 instruction/cycle.
  - ack=0, no stall: if_valid<=0 (bubble). if_pc/if_inst keep their last value.
  - ack=1, stall=1: store {pc_reg, mem_rdata} in the skid buffer, pc_reg<=pc_reg+PC_STEP, go to HOLD. IF outputs are unchanged.
  - ack=0, stall=1: IF outputs are unchanged; the request stays outstanding.
- HOLD: mem_req=0. IF outputs are held while stall=1.
  - When stall=0: present the buffered word (if_valid<=1) and return to REQ.
- Branch (branch_flag=1): takes priority over stall and over ack data.
  - pc_reg<=branch_target_addr with bits [1:0] forced to 0.
  - if_valid<=0 on the next edge (flushes the wrong-path slot).
  - Skid buffer is emptied.
  - If state is REQ and ack=0 this cycle, go to KILL. Otherwise go to REQ.
- KILL: mem_req stays high with the stale mem_addr until ack.
  - The acked data is discarded; if_valid stays 0.
  - Then go to REQ with the target PC.
  - A second branch in KILL overwrites pc_reg and the state stays KILL.
- Stall without branch never changes if_pc, if_inst or if_valid.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- mem_addr[1:0] is always 2'b00.

Test Plan:
1. Reset then release, memory acks every cycle, rdata=addr^32'hA5A5_0000 -> mem_addr 0,4,8,… on consecutive cycles; if_pc 0,4,8 with matching if_inst, one cycle after each ack; if_valid=1 continuously.
2. Ack delayed 3 cycles for addr 8 -> mem_req/mem_addr=8 held for 3 cycles; if_valid=0 for 2 cycles; then if_pc=8 with its data.
3. stall=1 for 4 cycles, asserted on the cycle ack for addr 12 arrives -> IF outputs frozen at the addr 8 values; mem_req=0 during HOLD; the cycle after stall drops, if_pc=12; next fetch is 16.
4. branch_flag=1 with target 32'h0000_0103 while the fetch of addr 20 is outstanding (ack 2 cycles later) -> state KILL; addr 20 data discarded; if_valid=0; next mem_addr=32'h0000_0100; then if_pc=0x100.
5. branch_flag=1 and stall=1 in the same cycle as an ack -> the acked word is not presented; pc_reg=target; if_valid=0.
6. Branch to 32'hFFFF_FFFC -> fetches 32'hFFFF_FFFC then 32'h0000_0000; rst=1 asserted mid-request -> next cycle mem_req=0, if_valid=0, and the first fetch after release is at RESET_PC.
